// File: rtl/ofdm_mod_pkg.sv
// ofdm_mod_pkg: shared widths, scale constants and the 16-QAM Gray level lookup for ofdm_mod.
//   SAMPLE_W  sample width (12-bit two's complement, unit amplitude = 1024)
//   N_SC      data subcarriers per OFDM symbol
package ofdm_mod_pkg;

    localparam int SAMPLE_W = 12;
    localparam int N_SC     = 48;

    localparam int BPSK_A = 1024;
    localparam int QPSK_A = 724;
    localparam int QAM_A1 = 324;
    localparam int QAM_A3 = 971;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    localparam sample_t BPSK_P = sample_t'(BPSK_A);
    localparam sample_t BPSK_N = sample_t'(-BPSK_A);
    localparam sample_t QPSK_P = sample_t'(QPSK_A);
    localparam sample_t QPSK_N = sample_t'(-QPSK_A);

    // b[1] is the earlier bit of the pair: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3
    function automatic sample_t gray_level(input logic [1:0] b);
        return b[1] ? (b[0] ? sample_t'(QAM_A1) : sample_t'(QAM_A3))
                    : (b[0] ? sample_t'(-QAM_A1) : sample_t'(-QAM_A3));
    endfunction

endpackage

// File: rtl/ofdm_mod_payload_mapper.sv
// ofdm_mod_payload_mapper: groups payload bits, maps them to QPSK (or 16-QAM) and counts subcarriers.
//   Build option: MOD_PAYLOAD_16QAM_EN selects 16-QAM (4 bits/sample), otherwise QPSK (2 bits/sample).
//   clk, rst          payload clock, asynchronous active-high reset
//   di, di_vld        encoded bit and its qualifier
//   do_re, do_im      registered constellation point
//   do_sym_end        high with the 48th sample of each OFDM symbol
//   do_vld            single-cycle sample strobe
module ofdm_mod_payload_mapper
    import ofdm_mod_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                di,
    input  logic                di_vld,
    output logic [SAMPLE_W-1:0] do_re,
    output logic [SAMPLE_W-1:0] do_im,
    output logic                do_sym_end,
    output logic                do_vld
);

`ifdef MOD_PAYLOAD_16QAM_EN
    localparam int BPS = 4;
`else
    localparam int BPS = 2;
`endif

    // held[0] is the most recent earlier bit of the group; older bits shift upward
    logic [2:0]             held;
    logic [$clog2(BPS)-1:0] cnt;
    logic [5:0]             sc;
    logic                   last;
    sample_t                map_re;
    sample_t                map_im;

    assign last = di_vld && (&cnt);

    always_comb begin
`ifdef MOD_PAYLOAD_16QAM_EN
        map_re = gray_level(held[2:1]);
        map_im = gray_level({held[0], di});
`else
        map_re = held[0] ? QPSK_P : QPSK_N;
        map_im = di ? QPSK_P : QPSK_N;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held       <= '0;
            cnt        <= '0;
            sc         <= '0;
            do_re      <= '0;
            do_im      <= '0;
            do_sym_end <= 1'b0;
            do_vld     <= 1'b0;
        end else begin
            do_vld     <= last;
            do_sym_end <= last && (sc == 6'(N_SC - 1));
            if (di_vld) begin
                cnt  <= cnt + 1'b1;
                held <= {held[1:0], di};
            end
            if (last) begin
                do_re <= map_re;
                do_im <= map_im;
                sc    <= (sc == 6'(N_SC - 1)) ? '0 : sc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ofdm_mod.sv
// ofdm_mod: OFDM constellation mapper, BPSK SIGNAL channel and QPSK/16-QAM PAYLOAD channel in separate clock domains.
//   Build option: MOD_PAYLOAD_16QAM_EN switches the PAYLOAD channel to 16-QAM.
//   signal_clk, signal_rst     SIGNAL domain clock, asynchronous active-high reset
//   signal_di, signal_di_vld   encoded header bit and qualifier
//   signal_do_re/im/vld        BPSK sample (im always 0) and strobe
//   payload_clk, payload_rst   PAYLOAD domain clock, asynchronous active-high reset
//   payload_di, payload_di_vld encoded data bit and qualifier
//   payload_do_re/im           PAYLOAD constellation point
//   payload_do_sym_end         last subcarrier of each OFDM symbol
//   payload_do_vld             PAYLOAD sample strobe
module ofdm_mod
    import ofdm_mod_pkg::*;
(
    input  logic                signal_clk,
    input  logic                signal_rst,
    input  logic                payload_clk,
    input  logic                payload_rst,
    input  logic                signal_di,
    input  logic                signal_di_vld,
    output logic [SAMPLE_W-1:0] signal_do_re,
    output logic [SAMPLE_W-1:0] signal_do_im,
    output logic                signal_do_vld,
    input  logic                payload_di,
    input  logic                payload_di_vld,
    output logic [SAMPLE_W-1:0] payload_do_re,
    output logic [SAMPLE_W-1:0] payload_do_im,
    output logic                payload_do_sym_end,
    output logic                payload_do_vld
);

    assign signal_do_im = '0;

    always_ff @(posedge signal_clk or posedge signal_rst) begin
        if (signal_rst) begin
            signal_do_re  <= '0;
            signal_do_vld <= 1'b0;
        end else begin
            signal_do_vld <= signal_di_vld;
            if (signal_di_vld)
                signal_do_re <= signal_di ? BPSK_P : BPSK_N;
        end
    end

    ofdm_mod_payload_mapper u_payload (
        .clk        (payload_clk),
        .rst        (payload_rst),
        .di         (payload_di),
        .di_vld     (payload_di_vld),
        .do_re      (payload_do_re),
        .do_im      (payload_do_im),
        .do_sym_end (payload_do_sym_end),
        .do_vld     (payload_do_vld)
    );

endmodule

// File: tb/tb_ofdm_mod.sv
// tb_ofdm_mod: table-driven self-checking bench for ofdm_mod (SIGNAL BPSK, PAYLOAD mapping, symbol boundary, gap, reset).
module tb_ofdm_mod;

`ifdef MOD_PAYLOAD_16QAM_EN
    localparam int BPS = 4;
`else
    localparam int BPS = 2;
`endif

    logic        signal_clk = 1'b0;
    logic        payload_clk = 1'b0;
    logic        signal_rst = 1'b1;
    logic        payload_rst = 1'b1;
    logic        signal_di = 1'b0;
    logic        signal_di_vld = 1'b0;
    logic [11:0] signal_do_re;
    logic [11:0] signal_do_im;
    logic        signal_do_vld;
    logic        payload_di = 1'b0;
    logic        payload_di_vld = 1'b0;
    logic [11:0] payload_do_re;
    logic [11:0] payload_do_im;
    logic        payload_do_sym_end;
    logic        payload_do_vld;

    int tests = 0;
    int fails = 0;

    always #5 signal_clk = ~signal_clk;
    always #7 payload_clk = ~payload_clk;

    ofdm_mod dut (
        .signal_clk         (signal_clk),
        .signal_rst         (signal_rst),
        .payload_clk        (payload_clk),
        .payload_rst        (payload_rst),
        .signal_di          (signal_di),
        .signal_di_vld      (signal_di_vld),
        .signal_do_re       (signal_do_re),
        .signal_do_im       (signal_do_im),
        .signal_do_vld      (signal_do_vld),
        .payload_di         (payload_di),
        .payload_di_vld     (payload_di_vld),
        .payload_do_re      (payload_do_re),
        .payload_do_im      (payload_do_im),
        .payload_do_sym_end (payload_do_sym_end),
        .payload_do_vld     (payload_do_vld)
    );

    typedef struct {
        logic        b;
        logic [11:0] re;
    } svec_t;

    typedef struct {
        logic [3:0]  bits;
        logic [11:0] re;
        logic [11:0] im;
    } pvec_t;

    svec_t sv[4];
    pvec_t pv[4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        payload_di     = b;
        payload_di_vld = 1'b1;
        @(posedge payload_clk);
        #1;
        payload_di_vld = 1'b0;
    endtask

    logic [3:0]  gap_bits, rst_bits;
    logic [11:0] gap_re, gap_im, rst_re, rst_im;
    int          n_smp, n_end;

    initial begin
        sv[0] = '{1'b1, 12'h400};
        sv[1] = '{1'b0, 12'hC00};
        sv[2] = '{1'b0, 12'hC00};
        sv[3] = '{1'b1, 12'h400};
`ifdef MOD_PAYLOAD_16QAM_EN
        pv[0] = '{4'b1000, 12'h3CB, 12'hC35};
        pv[1] = '{4'b0111, 12'hEBC, 12'h144};
        pv[2] = '{4'b1110, 12'h144, 12'h3CB};
        pv[3] = '{4'b0001, 12'hC35, 12'hEBC};
        gap_bits = 4'b1000; gap_re = 12'h3CB; gap_im = 12'hC35;
        rst_bits = 4'b0111; rst_re = 12'hEBC; rst_im = 12'h144;
`else
        pv[0] = '{4'b0011, 12'h2D4, 12'h2D4};
        pv[1] = '{4'b0000, 12'hD2C, 12'hD2C};
        pv[2] = '{4'b0010, 12'h2D4, 12'hD2C};
        pv[3] = '{4'b0001, 12'hD2C, 12'h2D4};
        gap_bits = 4'b0010; gap_re = 12'h2D4; gap_im = 12'hD2C;
        rst_bits = 4'b0001; rst_re = 12'hD2C; rst_im = 12'h2D4;
`endif

        #1;
        chk("rst_sig_re", signal_do_re, 0);
        chk("rst_sig_im", signal_do_im, 0);
        chk("rst_sig_vld", signal_do_vld, 0);
        chk("rst_pl_re", payload_do_re, 0);
        chk("rst_pl_im", payload_do_im, 0);
        chk("rst_pl_end", payload_do_sym_end, 0);
        chk("rst_pl_vld", payload_do_vld, 0);
        repeat (3) @(posedge signal_clk);
        #1 signal_rst = 1'b0;
        repeat (3) @(posedge payload_clk);
        #1 payload_rst = 1'b0;

        @(posedge signal_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            signal_di     = sv[i].b;
            signal_di_vld = 1'b1;
            @(posedge signal_clk);
            #1;
            chk("sig_vld", signal_do_vld, 1);
            chk("sig_re", signal_do_re, sv[i].re);
            chk("sig_im", signal_do_im, 0);
        end
        signal_di_vld = 1'b0;
        signal_di     = 1'b0;
        @(posedge signal_clk);
        #1;
        chk("sig_vld_idle", signal_do_vld, 0);
        chk("sig_re_hold", signal_do_re, 12'h400);

        for (int i = 0; i < 4; i++) begin
            for (int k = BPS - 1; k >= 0; k--) begin
                send_bit(pv[i].bits[k]);
                if (k != 0)
                    chk("pl_vld_partial", payload_do_vld, 0);
            end
            chk("pl_vld", payload_do_vld, 1);
            chk("pl_re", payload_do_re, pv[i].re);
            chk("pl_im", payload_do_im, pv[i].im);
            chk("pl_end", payload_do_sym_end, 0);
        end
        @(posedge payload_clk);
        #1;
        chk("pl_vld_pulse", payload_do_vld, 0);
        chk("pl_re_hold", payload_do_re, pv[3].re);

        send_bit(gap_bits[BPS-1]);
        repeat (5) @(posedge payload_clk);
        #1;
        chk("gap_vld", payload_do_vld, 0);
        for (int k = BPS - 2; k >= 0; k--)
            send_bit(gap_bits[k]);
        chk("gap_out_vld", payload_do_vld, 1);
        chk("gap_re", payload_do_re, gap_re);
        chk("gap_im", payload_do_im, gap_im);

        send_bit(1'b1);
        payload_rst = 1'b1;
        @(posedge payload_clk);
        #1;
        chk("mid_rst_vld", payload_do_vld, 0);
        chk("mid_rst_re", payload_do_re, 0);
        chk("sig_untouched", signal_do_re, 12'h400);
        payload_rst = 1'b0;
        @(posedge payload_clk);
        #1;
        for (int k = BPS - 1; k >= 0; k--) begin
            send_bit(rst_bits[k]);
            if (k != 0)
                chk("post_rst_partial", payload_do_vld, 0);
        end
        chk("post_rst_vld", payload_do_vld, 1);
        chk("post_rst_re", payload_do_re, rst_re);
        chk("post_rst_im", payload_do_im, rst_im);

        payload_rst = 1'b1;
        @(posedge payload_clk);
        #1 payload_rst = 1'b0;
        n_smp = 0;
        n_end = 0;
        for (int i = 0; i < BPS * 480; i++) begin
            payload_di     = 1'($urandom_range(0, 1));
            payload_di_vld = 1'b1;
            @(posedge payload_clk);
            #1;
            if (payload_do_sym_end)
                n_end++;
            if (payload_do_vld) begin
                n_smp++;
                chk("sym_end_pos", payload_do_sym_end, (n_smp % 48) == 0);
            end
        end
        payload_di_vld = 1'b0;
        chk("sym_samples", n_smp, 480);
        chk("sym_pulses", n_end, 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
